// File: rtl/adder2comp_datapath.sv
// adder2comp_datapath: sign-magnitude datapath for the two's-complement
// adder/subtractor. It is driven step by step by the adder control unit and
// delivers R/OVF through a valid/ready output register with a sticky overrun
// flag.
// Optional build macro: ADDER_OVF_SAT_EN saturates R on overflow. When the
// macro is undefined, R wraps to the low N bits of the true result.
module adder2comp_datapath #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         SUB,
  input  logic         loadAB,
  input  logic         loadmagAB,
  input  logic         compmag,
  input  logic         compsigns,
  input  logic         add_sub,
  input  logic         loadres,
  input  logic         res_ready,
  output logic [N-1:0] R,
  output logic         OVF,
  output logic         res_valid,
  output logic         ovr
);

  // 2^(N-1) in N+1 bits is the largest negative magnitude that still fits.
  localparam logic [N:0]   HALF    = {2'b01, {(N-1){1'b0}}};
  localparam logic [N:0]   HALF_M1 = HALF - 1'b1;
`ifdef ADDER_OVF_SAT_EN
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

  logic [N-1:0] regA, regB, magA, magB;
  logic         sA, sBe, ge, same;
  logic [N:0]   magR;
  logic         sR;
  logic         ldr_d;

  logic [N:0]   mag_nxt;
  logic         sgn_nxt;
  logic [N-1:0] r_wrap, r_nxt;
  logic         ovf_nxt;
  logic         cap;

  // Signed-magnitude add/sub of the stored magnitudes; a zero magnitude is
  // forced positive so that -0 never appears.
  always_comb begin
    mag_nxt = '0;
    sgn_nxt = sA;
    if (same) begin
      mag_nxt = {1'b0, magA} + {1'b0, magB};
    end else if (ge) begin
      mag_nxt = {1'b0, magA} - {1'b0, magB};
    end else begin
      mag_nxt = {1'b0, magB} - {1'b0, magA};
      sgn_nxt = sBe;
    end
    if (mag_nxt == '0) sgn_nxt = 1'b0;
  end

  // Re-encode magR/sR to two's complement and flag results out of range.
  always_comb begin
    r_wrap  = sR ? -magR[N-1:0] : magR[N-1:0];
    ovf_nxt = sR ? (magR > HALF) : (magR > HALF_M1);
`ifdef ADDER_OVF_SAT_EN
    r_nxt   = ovf_nxt ? (sR ? SAT_NEG : SAT_POS) : r_wrap;
`else
    r_nxt   = r_wrap;
`endif
  end

  assign cap = loadres & ~ldr_d;

  // Step registers: each strobe updates only its own state from pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      regA <= '0; regB <= '0; sA <= 1'b0; sBe <= 1'b0;
      magA <= '0; magB <= '0; ge <= 1'b0; same <= 1'b0;
      magR <= '0; sR <= 1'b0;
    end else begin
      if (loadAB) begin
        regA <= A;
        regB <= B;
        sA   <= A[N-1];
        sBe  <= B[N-1] ^ SUB;
      end
      if (loadmagAB) begin
        magA <= sA ? -regA : regA;
        magB <= regB[N-1] ? -regB : regB;
      end
      if (compmag)   ge   <= (magA >= magB);
      if (compsigns) same <= (sA == sBe);
      if (add_sub) begin
        magR <= mag_nxt;
        sR   <= sgn_nxt;
      end
    end
  end

  // Output register. A capture is taken only on the rising edge of loadres.
  // ldr_d resets high so that a held loadres needs a fresh 0->1 transition.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      R         <= '0;
      OVF       <= 1'b0;
      res_valid <= 1'b0;
      ovr       <= 1'b0;
      ldr_d     <= 1'b1;
    end else begin
      ldr_d <= loadres;
      if (cap) begin
        R         <= r_nxt;
        OVF       <= ovf_nxt;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) ovr <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder2comp_datapath.sv
// Bench for adder2comp_datapath. It uses directed test-plan vectors with
// literal expectations and then randomized standard sequences. A behavioural
// model built from integer arithmetic is compared against the DUT on every
// falling edge.
module tb_adder2comp_datapath;
  localparam int N    = 8;
  localparam int MAXV = (1 << (N-1)) - 1;
  localparam int MINV = -(1 << (N-1));

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] A = '0, B = '0;
  logic         SUB = 1'b0;
  logic         loadAB = 1'b0, loadmagAB = 1'b0, compmag = 1'b0, compsigns = 1'b0;
  logic         add_sub = 1'b0, loadres = 1'b0, res_ready = 1'b0;
  logic [N-1:0] R;
  logic         OVF, res_valid, ovr;

  int checks = 0;
  int errors = 0;

  adder2comp_datapath #(.N(N)) dut (
    .clk(clk), .RESET(RESET), .A(A), .B(B), .SUB(SUB),
    .loadAB(loadAB), .loadmagAB(loadmagAB), .compmag(compmag),
    .compsigns(compsigns), .add_sub(add_sub), .loadres(loadres),
    .res_ready(res_ready), .R(R), .OVF(OVF), .res_valid(res_valid), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: true integer result, range check, then wrap or saturate.
  function automatic void ref_res(input int t, output logic [N-1:0] r, output logic o);
    int tt;
    tt = t;
    o  = (t > MAXV) || (t < MINV);
    r  = tt[N-1:0];
`ifdef ADDER_OVF_SAT_EN
    if (o) begin
      tt = (t > 0) ? MAXV : MINV;
      r  = tt[N-1:0];
    end
`endif
  endfunction

  // Behavioural model. The bench only drives complete standard sequences, so
  // the value produced by add_sub is the sum or difference latched at loadAB.
  int           t_load = 0, t_res = 0;
  logic         m_ldr = 1'b1, m_valid = 1'b0, m_ovr = 1'b0, m_ovf = 1'b0;
  logic [N-1:0] m_r = '0;

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      t_load = 0; t_res = 0; m_ldr = 1'b1;
      m_valid = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_r = '0;
    end else begin
      if (add_sub) t_res = t_load;
      if (loadAB)
        t_load = SUB ? int'($signed(A)) - int'($signed(B))
                     : int'($signed(A)) + int'($signed(B));
      if (loadres && !m_ldr) begin
        ref_res(t_res, m_r, m_ovf);
        if (m_valid && !res_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      m_ldr = loadres;
    end
  end

  // Compare the DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    chk("cmp_R", int'(R), int'(m_r));
    chk("cmp_OVF", int'(OVF), int'(m_ovf));
    chk("cmp_valid", int'(res_valid), int'(m_valid));
    chk("cmp_ovr", int'(ovr), int'(m_ovr));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive the sequence up to and including add_sub. A/B/SUB are scrambled
  // outside the loadAB cycle because they must be ignored there.
  task automatic pre_seq(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    A = a; B = b; SUB = s; loadAB = 1'b1; cyc(); loadAB = 1'b0;
    A = N'($urandom); B = N'($urandom); SUB = 1'($urandom);
    loadmagAB = 1'b1; cyc(); loadmagAB = 1'b0;
    compmag   = 1'b1; cyc(); compmag   = 1'b0;
    compsigns = 1'b1; cyc(); compsigns = 1'b0;
    add_sub   = 1'b1; cyc(); add_sub   = 1'b0;
  endtask

  task automatic run_seq(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic rdy);
    pre_seq(a, b, s);
    loadres = 1'b1; res_ready = rdy; cyc();
    loadres = 1'b0; res_ready = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1; cyc(); res_ready = 1'b0;
  endtask

  task automatic dir(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic s, input logic [N-1:0] er, input logic eo);
    run_seq(a, b, s, 1'b0);
    chk({nm, "_R"}, int'(R), int'(er));
    chk({nm, "_OVF"}, int'(OVF), int'(eo));
    chk({nm, "_valid"}, int'(res_valid), 1);
    drain();
    chk({nm, "_drained"}, int'(res_valid), 0);
  endtask

  initial begin
    cyc(); cyc();
    RESET = 1'b0;
    chk("rst_R", int'(R), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_ovr", int'(ovr), 0);
    cyc();

    dir("add5p3", 8'd5, 8'd3, 1'b0, 8'h08, 1'b0);
    dir("m3m7", 8'hFD, 8'd7, 1'b1, 8'hF6, 1'b0);
    dir("5m5", 8'd5, 8'd5, 1'b1, 8'h00, 1'b0);
`ifdef ADDER_OVF_SAT_EN
    dir("100p50", 8'd100, 8'd50, 1'b0, 8'h7F, 1'b1);
    dir("m128m1", 8'h80, 8'hFF, 1'b0, 8'h80, 1'b1);
`else
    dir("100p50", 8'd100, 8'd50, 1'b0, 8'h96, 1'b1);
    dir("m128m1", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
`endif
    dir("m128p0", 8'h80, 8'd0, 1'b0, 8'h80, 1'b0);

    // A capture and an accept in the same cycle keep res_valid high.
    run_seq(8'd1, 8'd2, 1'b0, 1'b0);
    run_seq(8'd7, 8'd9, 1'b1, 1'b1);
    chk("capacc_valid", int'(res_valid), 1);
    chk("capacc_ovr", int'(ovr), 0);
    chk("capacc_R", int'(R), 8'hFE);
    drain();

    // Two results with no accept: the second result overwrites and ovr sets.
    run_seq(8'd10, 8'd20, 1'b0, 1'b0);
    run_seq(8'hF0, 8'd1, 1'b1, 1'b0);
    chk("ovw_R", int'(R), 8'hEF);
    chk("ovw_ovr", int'(ovr), 1);
    drain();
    chk("ovr_sticky", int'(ovr), 1);

    // Reset mid-operation with loadres held through the release.
    pre_seq(8'd5, 8'd3, 1'b0);
    loadres = 1'b1; RESET = 1'b1; cyc();
    chk("midrst_R", int'(R), 0);
    chk("midrst_ovr", int'(ovr), 0);
    RESET = 1'b0; cyc(); cyc();
    chk("midrst_nocap", int'(res_valid), 0);
    loadres = 1'b0; cyc();
    loadres = 1'b1; cyc();
    chk("midrst_cap", int'(res_valid), 1);
    chk("midrst_capR", int'(R), 0);
    loadres = 1'b0; drain();

    // Holding loadres high for ten cycles gives exactly one capture.
    pre_seq(8'd33, 8'd44, 1'b1);
    loadres = 1'b1;
    for (int i = 0; i < 10; i++) begin
      res_ready = (i == 3);
      cyc();
    end
    res_ready = 1'b0;
    chk("hold_valid", int'(res_valid), 0);
    chk("hold_R", int'(R), 8'hF5);
    loadres = 1'b0; cyc();

    // Randomized standard sequences with a random consumer.
    for (int k = 0; k < 60; k++) begin
      run_seq(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) drain();
    end
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
